// File: rtl/ysyx_220578_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220578_ifu_pkg
// Purpose  : Shared types and constants for the multi-cycle instruction fetch
//            unit: FSM state encoding and the default reset PC and PC step.
//            The INST_ZERO constant is used for fault-only deliveries.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_220578_ifu_pkg;

  // Fetch FSM: issue request, wait for the response, drop a squashed
  // response, hold the result until the decoder takes it.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [63:0] C_RESET_PC  = 64'h0000_0000_8000_0000;
  localparam int          C_PC_STEP   = 4;
  localparam logic [31:0] C_INST_ZERO = 32'h0000_0000;

endpackage : ysyx_220578_ifu_pkg
`default_nettype wire

// File: rtl/ysyx_220578_ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220578_ifu_pc_gen
// Purpose  : Program counter register of the fetch unit.
//            Priority: reset > redirect > advance > hold.
// Ports    : clk, rst (async, active-low)
//            i_redirect_valid / i_redirect_pc : load a new PC
//            i_advance                        : step PC after a delivery
//            o_pc                             : current PC
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_220578_ifu_pc_gen #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(64'h8000_0000),
  parameter int                  PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_redirect_valid,
  input  logic [PC_WIDTH-1:0] i_redirect_pc,
  input  logic                i_advance,
  output logic [PC_WIDTH-1:0] o_pc
);

  localparam logic [PC_WIDTH-1:0] C_STEP = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0] r_pc;

  // The add wraps naturally at the top of the address space.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      r_pc <= i_redirect_pc;
    end else if (i_advance) begin
      r_pc <= r_pc + C_STEP;
    end
  end

  assign o_pc = r_pc;

endmodule : ysyx_220578_ifu_pc_gen
`default_nettype wire

// File: rtl/ysyx_220578_ifu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220578_ifu_multicycle
// Purpose  : Multi-cycle instruction fetch unit with its own PC. Issues one
//            request at a time to instruction memory over valid/ready request
//            and response channels and hands each instruction with its PC and
//            fault flag to the decoder over a valid/ready channel. A redirect
//            is accepted in any cycle and squashes any in-flight fetch.
// Ports    : clk, rst (async, active-low)
//            imem_req_*  : fetch request (valid/ready/addr)
//            imem_rsp_*  : fetch response (valid/ready/inst/err)
//            redirect_*  : new PC target
//            out_*       : instruction to decoder (valid/ready/inst/pc/err)
// Options  : YSYX_220578_IFU_MISALIGN_CHK_EN - when defined, a PC with
//            nonzero low two bits is not fetched; a fault-only instruction
//            (inst 0, err 1) is delivered instead.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_220578_ifu_multicycle
  import ysyx_220578_ifu_pkg::*;
#(
  parameter int                  PC_WIDTH   = 64,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(C_RESET_PC),
  parameter int                  PC_STEP    = C_PC_STEP
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  output logic                  imem_rsp_ready,
  input  logic [INST_WIDTH-1:0] imem_rsp_inst,
  input  logic                  imem_rsp_err,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  out_err
);

  ifu_state_e            r_state;
  ifu_state_e            w_next;
  logic [PC_WIDTH-1:0]   w_pc;
  logic                  w_misalign;
  logic                  w_req_valid;
  logic                  w_rsp_ready;
  logic                  w_capture;
  logic                  w_fault;
  logic                  w_advance;
  logic                  w_release;

  logic                  r_out_valid;
  logic [INST_WIDTH-1:0] r_out_inst;
  logic [PC_WIDTH-1:0]   r_out_pc;
  logic                  r_out_err;

  ysyx_220578_ifu_pc_gen #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_advance        (w_advance),
    .o_pc             (w_pc)
  );

`ifdef YSYX_220578_IFU_MISALIGN_CHK_EN
  assign w_misalign = (w_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_valid = 1'b0;
    w_rsp_ready = 1'b0;
    w_capture   = 1'b0;
    w_fault     = 1'b0;
    w_advance   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_REQ: begin
        // A redirect in this cycle only reloads the PC; the request is
        // withheld so the address never changes under a valid request.
        if (!redirect_valid) begin
          if (w_misalign) begin
            w_fault = 1'b1;
            w_next  = S_HOLD;
          end else begin
            w_req_valid = 1'b1;
            if (imem_req_ready) begin
              w_next = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        w_rsp_ready = 1'b1;
        if (redirect_valid) begin
          // If the response is arriving now it is consumed and dropped here,
          // otherwise it is still owed and must be drained in S_DROP.
          w_next = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          w_capture = 1'b1;
          w_next    = S_HOLD;
        end
      end
      S_DROP: begin
        w_rsp_ready = 1'b1;
        // The owed response is swallowed even if a further redirect arrives
        // with it; waiting for another response would deadlock.
        if (imem_rsp_valid) begin
          w_next = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_release = 1'b1;
          w_next    = S_REQ;
        end else if (out_ready) begin
          w_release = 1'b1;
          w_advance = 1'b1;
          w_next    = S_REQ;
        end
      end
      default: begin
        w_next = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_pc    <= '0;
      r_out_err   <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_inst  <= imem_rsp_inst;
      r_out_pc    <= w_pc;
      r_out_err   <= imem_rsp_err;
    end else if (w_fault) begin
      r_out_valid <= 1'b1;
      r_out_inst  <= INST_WIDTH'(C_INST_ZERO);
      r_out_pc    <= w_pc;
      r_out_err   <= 1'b1;
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  // The request strobe is masked by reset because the reset state itself
  // would otherwise present a request whenever no redirect is pending.
  assign imem_req_valid = w_req_valid & rst;
  assign imem_req_addr  = w_pc;
  assign imem_rsp_ready = w_rsp_ready;
  assign out_valid      = r_out_valid;
  assign out_inst       = r_out_inst;
  assign out_pc         = r_out_pc;
  assign out_err        = r_out_err;

endmodule : ysyx_220578_ifu_multicycle
`default_nettype wire

// File: doc/ysyx_220578_ifu_multicycle.md
Name: ysyx_220578_ifu_multicycle

Overview:
Multi-cycle instruction fetch unit with its own PC register.
- Replaces the single-cycle combinational PC-register + IFU pair.
- Talks to instruction memory over valid/ready request and response channels, so memory latency can vary.
- Presents each fetched instruction and its PC to the IDU over a valid/ready output channel.
- Accepts a redirect (branch/jump/trap target) at any cycle.

Parameters:
PC_WIDTH, 64, width of PC and memory address
INST_WIDTH, 32, width of fetched instruction
RESET_PC, 64'h8000_0000, PC value loaded at reset
PC_STEP, 4, PC increment after an instruction is accepted downstream

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  PC_WIDTH  fetch address
imem_rsp_valid  in  1  response valid
imem_rsp_ready  out  1  IFU accepts response
imem_rsp_inst  in  INST_WIDTH  fetched instruction
imem_rsp_err  in  1  access fault for this response
redirect_valid  in  1  load new PC, squash in-flight fetch
redirect_pc  in  PC_WIDTH  redirect target
out_valid  out  1  instruction valid to IDU
out_ready  in  1  IDU accepts instruction
out_inst  out  INST_WIDTH  instruction to IDU
out_pc  out  PC_WIDTH  PC of out_inst
out_err  out  1  fetch fault flag for out_inst

Behaviour:
Reset (rst low, asynchronous):
- state=REQ, pc=RESET_PC.
- out_valid=0, out_inst=0, out_pc=0, out_err=0.
- imem_req_valid=0 while rst is low.
- imem_rsp_ready=0.

FSM states: REQ, WAIT, DROP, HOLD. All outputs are registered except the handshake strobes, which decode from state.
- REQ:
  - imem_req_valid = !redirect_valid; imem_req_addr = pc.
  - If redirect_valid: pc<=redirect_pc, stay in REQ, no handshake this cycle.
  - Else if imem_req_ready: go to WAIT.
  - Address stays stable while valid is high and not yet accepted.
- WAIT:
  - imem_rsp_ready=1.
  - If redirect_valid (including the same cycle as rsp_valid): pc<=redirect_pc, response is not captured, go to DROP if !imem_rsp_valid, else go to REQ.
  - Else if imem_rsp_valid: out_inst<=imem_rsp_inst, out_err<=imem_rsp_err, out_pc<=pc, out_valid<=1, go to HOLD.
- DROP:
  - imem_rsp_ready=1; the pending response is discarded on imem_rsp_valid, then go to REQ.
  - A further redirect here updates pc and stays in DROP.
- HOLD:
  - out_valid=1; out_* are held stable.
  - If redirect_valid: out_valid<=0, pc<=redirect_pc, go to REQ; out_ready is ignored that cycle (instruction squashed).
  - Else if out_ready: out_valid<=0, pc<=pc+PC_STEP, go to REQ.
- Timing and arithmetic:
  - Minimum latency from REQ entry to out_valid is 2 cycles with zero-wait memory.
  - Peak throughput is 1 instruction per 3 cycles.
  - pc+PC_STEP wraps modulo 2^PC_WIDTH; the all-ones region wraps to 0 with no flag.
- Fault and memory-contract rules:
  - A faulted instruction (out_err=1) is delivered like any other. The IFU keeps fetching at pc+PC_STEP until redirected.
  - At most one request is outstanding. imem_rsp_valid outside WAIT/DROP is a memory protocol violation; it is ignored.

Optional Feature:
YSYX_220578_IFU_MISALIGN_CHK_EN
- Defined: in REQ with pc[1:0]!=0 and no redirect, no memory request is issued (imem_req_valid=0). The IFU goes directly to HOLD with out_inst=0, out_err=1, out_pc=pc.
- Undefined: no check; the full pc, including low bits, is driven on imem_req_addr unchanged.

Decomposition:
Package ysyx_220578_ifu_pkg:
- FSM state enum (REQ, WAIT, DROP, HOLD), 2 bits.
- Default RESET_PC and PC_STEP constants.
- INST_ZERO constant.
One sub-module: ysyx_220578_ifu_pc_gen.
- Holds the PC register.
- Priority: reset > redirect > advance (out handshake) > hold.
- Output: pc.

Test Plan:
- Reset release, zero-wait memory, out_ready=1 -> imem_req_addr 0x80000000, 0x80000004, 0x80000008 on successive REQ cycles; out_pc matches; one instruction every 3 cycles.
- Response delayed 5 cycles while imem_req_ready=1 -> IFU stays in WAIT with imem_rsp_ready=1; out_valid rises the cycle after rsp_valid; out_inst equals the returned word (e.g. 0x00000513).
- out_ready held low 4 cycles in HOLD -> out_valid, out_inst and out_pc stable; no new imem_req_valid until the accept cycle.
- redirect_valid to 0x80001000 in WAIT, response arrives 2 cycles later -> response discarded, no out_valid; next request address is 0x80001000.
- imem_rsp_err=1 on fetch at 0x80000010 -> out_err=1 with out_pc=0x80000010; after accept, the next fetch is 0x80000014 with out_err=0.
- rst asserted mid-WAIT, then a stale response -> all outputs 0 immediately; after release the first request is to RESET_PC. With MISALIGN_CHK_EN, redirect to 0x80000002 -> no memory request; out_err=1, out_pc=0x80000002.
